// File: rtl/axi4_lite_master_bridge_pkg.sv
// Shared AXI4-Lite definitions for the master bridge: response codes and FSM encoding.
// The slave side uses the same response constants.
package axi4_lite_master_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    function automatic logic is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
// Holds the last transaction result for the requester and a sticky error flag.
module axi4_lite_master_bridge
    import axi4_lite_master_bridge_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    // requester command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // requester response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              err_sticky,
    // write address channel
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    // write data channel
    output logic [DATA_W-1:0] WDATA,
    output logic              WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    // write response channel
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    // read address channel
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    // read data channel
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q,  rsp_resp_d;
    logic                err_q,       err_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of process ordering.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_q       <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        err_d       = err_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        WSTRB       = 1'b0;
        BREADY      = 1'b0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        state_d   = ST_RD_REQ;
                    end
                end
            end

            // AW and W complete independently; leave once neither is pending.
            ST_WR_REQ: begin
                WSTRB = 1'b1;
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = ST_WR_RESP;
            end

            ST_WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = BRESP;
                    err_d       = err_q | is_error(BRESP);
                    state_d     = ST_RSP;
                end
            end

            ST_RD_REQ: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = ST_RD_DATA;
            end

            ST_RD_DATA: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    err_d       = err_q | is_error(RRESP);
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign AWADDR     = addr_q;
    assign ARADDR     = addr_q;
    assign WDATA      = wdata_q;
    assign AWVALID    = awvalid_q;
    assign WVALID     = wvalid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: behavioural AXI4-Lite slave with per-channel
// ready/valid delays, a memory reference model and a latency model per transaction.
module tb_axi4_lite_master_bridge;
    import axi4_lite_master_bridge_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_write;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic       err_sticky;
    logic [7:0] AWADDR, WDATA, ARADDR, RDATA;
    logic       AWVALID, AWREADY, WSTRB, WVALID, WREADY;
    logic [1:0] BRESP, RRESP;
    logic       BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

    axi4_lite_master_bridge #(.ADDR_W(8), .DATA_W(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_sticky(err_sticky),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] inj_resp = RESP_OKAY;
    logic [7:0] slv_mem [256];

    bit         aw_done, w_done, ar_done;
    int         aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    logic [7:0] aw_a, w_d, ar_a;
    // what the next rising edge saw, captured at the preceding falling edge
    bit         s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
    logic [7:0] s_awaddr, s_wdata, s_araddr;

    task automatic slave_clear();
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        s_awv = 0; s_awr = 0; s_wv = 0; s_wr = 0; s_bv = 0; s_br = 0;
        s_arv = 0; s_arr = 0; s_rv = 0; s_rr = 0;
        AWREADY = 0; WREADY = 0; ARREADY = 0;
        BVALID = 0; RVALID = 0; BRESP = 2'b00; RRESP = 2'b00; RDATA = 8'h00;
    endtask

    initial begin : slave
        for (int i = 0; i < 256; i++) slv_mem[i] = 8'h00;
        slave_clear();
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                slave_clear();
            end else begin
                // a VALID left waiting must hold, with stable payload
                if (s_awv && !s_awr) check("aw_hold", 32'({AWVALID, AWADDR}), 32'({1'b1, s_awaddr}));
                if (s_wv && !s_wr)   check("w_hold",  32'({WVALID, WDATA}),   32'({1'b1, s_wdata}));
                if (s_arv && !s_arr) check("ar_hold", 32'({ARVALID, ARADDR}), 32'({1'b1, s_araddr}));

                if (s_awv && s_awr) begin aw_done = 1; aw_a = s_awaddr; end
                if (s_wv && s_wr)   begin w_done = 1;  w_d = s_wdata;   end
                if (s_arv && s_arr) begin ar_done = 1; ar_a = s_araddr; r_wait = 0; end
                if (s_bv && s_br)   begin BVALID = 0; aw_done = 0; w_done = 0; b_wait = 0; end
                if (s_rv && s_rr)   begin RVALID = 0; ar_done = 0; end

                if (aw_dly == 0) AWREADY = 1;
                else if (AWVALID && !aw_done) begin aw_cnt++; AWREADY = (aw_cnt > aw_dly); end
                else begin aw_cnt = 0; AWREADY = 0; end

                if (w_dly == 0) WREADY = 1;
                else if (WVALID && !w_done) begin w_cnt++; WREADY = (w_cnt > w_dly); end
                else begin w_cnt = 0; WREADY = 0; end

                if (ar_dly == 0) ARREADY = 1;
                else if (ARVALID && !ar_done) begin ar_cnt++; ARREADY = (ar_cnt > ar_dly); end
                else begin ar_cnt = 0; ARREADY = 0; end

                if (aw_done && w_done && !BVALID) begin
                    if (b_wait >= b_dly) begin
                        slv_mem[aw_a] = w_d;
                        BVALID = 1; BRESP = inj_resp;
                    end else b_wait++;
                end
                if (ar_done && !RVALID) begin
                    if (r_wait >= r_dly) begin
                        RVALID = 1; RDATA = slv_mem[ar_a]; RRESP = inj_resp;
                    end else r_wait++;
                end

                s_awv = AWVALID; s_awr = AWREADY; s_awaddr = AWADDR;
                s_wv  = WVALID;  s_wr  = WREADY;  s_wdata  = WDATA;
                s_arv = ARVALID; s_arr = ARREADY; s_araddr = ARADDR;
                s_bv  = BVALID;  s_br  = BREADY;
                s_rv  = RVALID;  s_rr  = RREADY;
            end
        end
    end

    // ---------------- reference model and driver ----------------
    logic [7:0] ref_mem [256];
    bit         exp_err = 0;

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // Entered and left at a falling edge with the bridge idle.
    task automatic do_txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [1:0] resp, input int hold, input string tag);
        int         lat, exp_lat, wr_max, wr_min;
        logic [7:0] exp_rdata;
        wr_max    = (aw_dly > w_dly) ? aw_dly : w_dly;
        wr_min    = (aw_dly > w_dly) ? w_dly : aw_dly;
        exp_lat   = wr ? wr_max + b_dly + 3 : ar_dly + r_dly + 3;
        exp_rdata = wr ? 8'h00 : ref_mem[a];
        if (wr) ref_mem[a] = d;
        if (resp != RESP_OKAY) exp_err = 1;
        inj_resp = resp;

        check({tag, ".idle"}, 32'(cmd_ready), 32'(1));
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        lat = 0;
        do begin
            @(negedge ACLK);
            lat++;
            if (lat == 1) begin
                cmd_valid = 0; cmd_write = 1'($urandom);
                cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
                check({tag, ".busy"}, 32'(cmd_ready), 32'(0));
                if (wr) check({tag, ".aw_w_rise"}, 32'({AWVALID, WVALID, WSTRB, AWADDR, WDATA}),
                              32'({3'b111, a, d}));
                else    check({tag, ".ar_rise"}, 32'({ARVALID, ARADDR}), 32'({1'b1, a}));
            end
            if (wr && aw_dly != w_dly && lat == wr_min + 2)
                check({tag, ".solo_valid"}, 32'({AWVALID, WVALID}),
                      32'((aw_dly > w_dly) ? 2'b10 : 2'b01));
            if (wr && lat == wr_max + 2)
                check({tag, ".bready"}, 32'({BREADY, AWVALID, WVALID}), 32'(3'b100));
            if (!wr && lat == ar_dly + 2)
                check({tag, ".rready"}, 32'({RREADY, ARVALID}), 32'(2'b10));
        end while (!rsp_valid && lat < 64);

        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rsp_write"}, 32'({rsp_valid, rsp_write}), 32'({1'b1, wr}));
        check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        check({tag, ".rsp_resp"}, 32'(rsp_resp), 32'(resp));
        check({tag, ".err_sticky"}, 32'(err_sticky), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check({tag, ".hold"}, 32'({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}),
                  32'({1'b1, 1'b0, wr, resp, exp_rdata}));
        end
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        check({tag, ".back_idle"}, 32'({rsp_valid, cmd_ready}), 32'(2'b01));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        #1 ARESETN = 0;
        #2;
        check("reset.ready", 32'({cmd_ready, rsp_valid}), 32'(2'b10));
        check("reset.valids", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 32'(0));
        check("reset.rsp", 32'({rsp_write, rsp_resp, rsp_rdata, err_sticky}), 32'(0));
        check("reset.addr", 32'({AWADDR, ARADDR, WDATA, WSTRB}), 32'(0));
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);

        // 1: write with all READYs pre-asserted, minimum latency
        set_dly(0, 0, 0, 0, 0);
        do_txn(1, 8'h10, 8'h3C, RESP_OKAY, 0, "t1_write");

        // 2: AWREADY lags WREADY by 3 cycles, then read the value back
        set_dly(3, 0, 0, 0, 0);
        do_txn(1, 8'h10, 8'h3C, RESP_OKAY, 0, "t2_write");
        set_dly(0, 0, 0, 0, 2);
        do_txn(0, 8'h10, 8'h00, RESP_OKAY, 0, "t2_read");

        // 3: SLVERR on read, sticky flag survives a later OKAY
        set_dly(0, 0, 0, 1, 0);
        do_txn(0, 8'hFF, 8'h00, RESP_SLVERR, 0, "t3_err_read");
        set_dly(0, 2, 1, 0, 0);
        do_txn(1, 8'h20, 8'hA5, RESP_OKAY, 0, "t3_ok_write");

        // 4: requester stalls the response for 4 cycles
        set_dly(0, 0, 0, 0, 0);
        do_txn(0, 8'h20, 8'h00, RESP_OKAY, 4, "t4_stall");

        // 5: reset while AWVALID waits for AWREADY
        set_dly(5, 0, 0, 0, 0);
        check("t5.idle", 32'(cmd_ready), 32'(1));
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h30; cmd_wdata = 8'h77;
        @(negedge ACLK);
        cmd_valid = 0;
        check("t5.aw_pending", 32'({AWVALID, AWREADY}), 32'(2'b10));
        #2 ARESETN = 0;
        #1;
        check("t5.async_clear", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}), 32'(0));
        check("t5.err_clear", 32'({cmd_ready, err_sticky}), 32'(2'b10));
        exp_err = 0;
        repeat (2) @(negedge ACLK);
        #2 ARESETN = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("t5.no_rsp", 32'({rsp_valid, cmd_ready, AWVALID, WVALID}), 32'(4'b0100));
        end
        set_dly(0, 0, 0, 0, 0);
        do_txn(0, 8'h30, 8'h00, RESP_OKAY, 0, "t5_after");

        // 6: random back-to-back traffic against the memory model
        for (int n = 0; n < 30; n++) begin
            logic [1:0] r;
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
            set_dly($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 5), $urandom_range(0, 5));
            do_txn(1'($urandom), 8'($urandom), 8'($urandom), r, $urandom_range(0, 3),
                   $sformatf("t6_%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
